xnor_cmp_sched: RTL and testbench

Round-robin scheduler that shares one external single-bit XNOR cell among N_REQ requesters to perform bit-serial W-bit equality compares. It grants one requester at a time, latches that requester's operand pair, drives the operands LSB-first into the XNOR cell, AND-accumulates the cell output, and returns a per-requester done pulse with the equality result. It sits between the requester logic and the gate-level XNOR datapath cell.

---
 rtl/xnor_cmp_sched.sv | 155 +++++++++++++++
 tb/tb_xnor_cmp_sched.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/xnor_cmp_sched.sv
// Round-robin scheduler that shares one external single-bit XNOR cell among
// N_REQ requesters and runs bit-serial, LSB-first W-bit equality compares.
module xnor_cmp_sched #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N_REQ = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_i,
  input  logic [N_REQ*WIDTH-1:0]   a_in_i,
  input  logic [N_REQ*WIDTH-1:0]   b_in_i,
  output logic [N_REQ-1:0]         gnt_o,
  output logic [N_REQ-1:0]         done_o,
  output logic                     eq_o,
  output logic                     busy_o,
  output logic                     xa_o,
  output logic                     xb_o,
  input  logic                     xnor_in_i
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned IW = $clog2(N_REQ);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, REPORT} state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    g_q, g_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             acc_q, acc_d;
  logic             eq_q, eq_d;

  logic [IW-1:0]    pick;
  logic             found;
  int unsigned      idx;
  logic             last_bit;

  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  // First set request searching upward from ptr+1, wrapping at N_REQ.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req_i[IW'(idx)]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (found) state_d = LOAD;
      LOAD:    state_d = SHIFT;
      SHIFT:   if (last_bit) state_d = REPORT;
      REPORT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    g_d   = g_q;
    ptr_d = ptr_q;
    sa_d  = sa_q;
    sb_d  = sb_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    eq_d  = eq_q;
    unique case (state_q)
      IDLE: if (found) g_d = pick;
      LOAD: begin
        for (int unsigned i = 0; i < N_REQ; i++) begin
          if (g_q == IW'(i)) begin
            sa_d = a_in_i[i*WIDTH +: WIDTH];
            sb_d = b_in_i[i*WIDTH +: WIDTH];
          end
        end
        cnt_d = '0;
        acc_d = 1'b1;
      end
      SHIFT: begin
        acc_d = acc_q & xnor_in_i;
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        cnt_d = cnt_q + CW'(1);
        // Result captured on the final shift edge so EQ is valid in REPORT.
        if (last_bit) eq_d = acc_q & xnor_in_i;
      end
      REPORT: ptr_d = g_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_q   <= '0;
      ptr_q <= IW'(N_REQ - 1);
      sa_q  <= '0;
      sb_q  <= '0;
      cnt_q <= '0;
      acc_q <= 1'b1;
      eq_q  <= 1'b0;
    end else begin
      g_q   <= g_d;
      ptr_q <= ptr_d;
      sa_q  <= sa_d;
      sb_q  <= sb_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      eq_q  <= eq_d;
    end
  end

  always_comb begin
    gnt_o  = '0;
    done_o = '0;
    busy_o = 1'b0;
    xa_o   = 1'b0;
    xb_o   = 1'b0;
    unique case (state_q)
      IDLE: ;
      LOAD: begin
        gnt_o  = N_REQ'(1) << g_q;
        busy_o = 1'b1;
      end
      SHIFT: begin
        gnt_o  = N_REQ'(1) << g_q;
        busy_o = 1'b1;
        xa_o   = sa_q[0];
        xb_o   = sb_q[0];
      end
      REPORT: begin
        gnt_o  = N_REQ'(1) << g_q;
        done_o = N_REQ'(1) << g_q;
        busy_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign eq_o = eq_q;

endmodule

// File: tb/tb_xnor_cmp_sched.sv
// Self-checking bench for xnor_cmp_sched: an 8-bit/4-requester instance and a
// 1-bit/2-requester instance, each with its XNOR cell modelled as ~(XA^XB).
module tb_xnor_cmp_sched;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  req0 = '0;
  logic [31:0] a0 = '0, b0 = '0;
  logic [3:0]  gnt0, done0;
  logic        eq0, busy0, xa0, xb0, xn0;
  assign xn0 = ~(xa0 ^ xb0);

  logic [1:0]  req1 = '0;
  logic [1:0]  a1 = '0, b1 = '0;
  logic [1:0]  gnt1, done1;
  logic        eq1, busy1, xa1, xb1, xn1;
  assign xn1 = ~(xa1 ^ xb1);

  xnor_cmp_sched #(.WIDTH(8), .N_REQ(4)) u0 (
    .clk(clk), .rst_n(rst_n), .req_i(req0), .a_in_i(a0), .b_in_i(b0),
    .gnt_o(gnt0), .done_o(done0), .eq_o(eq0), .busy_o(busy0),
    .xa_o(xa0), .xb_o(xb0), .xnor_in_i(xn0));

  xnor_cmp_sched #(.WIDTH(1), .N_REQ(2)) u1 (
    .clk(clk), .rst_n(rst_n), .req_i(req1), .a_in_i(a1), .b_in_i(b1),
    .gnt_o(gnt1), .done_o(done1), .eq_o(eq1), .busy_o(busy1),
    .xa_o(xa1), .xb_o(xb1), .xnor_in_i(xn1));

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: round-robin pointer, last reported result, operands.
  int       ptr0 = 3, ptr1 = 1;
  logic     eqp0 = 1'b0, eqp1 = 1'b0;
  logic [7:0] opa[4], opb[4];

  task automatic drive_ops();
    for (int i = 0; i < 4; i++) begin
      a0[i*8 +: 8] = opa[i];
      b0[i*8 +: 8] = opb[i];
    end
  endtask

  // Caller is at the falling edge of an IDLE cycle with req0 already set.
  task automatic txn0(input int drop_at);
    int exp_g;
    logic [3:0] oh;
    logic [7:0] ea, eb;
    logic exp_eq;
    exp_g = -1;
    for (int k = 1; k <= 4; k++)
      if (exp_g < 0 && req0[(ptr0 + k) % 4]) exp_g = (ptr0 + k) % 4;
    oh = 4'b0001 << exp_g;
    ea = opa[exp_g];
    eb = opb[exp_g];
    exp_eq = (ea == eb);
    @(negedge clk);
    n_cmp++; if (gnt0 !== oh) begin n_err++; $display("FAIL load_gnt: got %b want %b", gnt0, oh); end
    n_cmp++; if (busy0 !== 1'b1) begin n_err++; $display("FAIL load_busy: got %b want 1", busy0); end
    n_cmp++; if (done0 !== 4'b0) begin n_err++; $display("FAIL load_done: got %b want 0000", done0); end
    n_cmp++; if (eq0 !== eqp0) begin n_err++; $display("FAIL eq_hold: got %b want %b", eq0, eqp0); end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == drop_at) req0 = 4'b0000;
      if (k == 0) begin a0 = $urandom; b0 = $urandom; end
      n_cmp++; if (xa0 !== ea[k]) begin n_err++; $display("FAIL shift_xa[%0d]: got %b want %b", k, xa0, ea[k]); end
      n_cmp++; if (xb0 !== eb[k]) begin n_err++; $display("FAIL shift_xb[%0d]: got %b want %b", k, xb0, eb[k]); end
      n_cmp++; if (gnt0 !== oh || busy0 !== 1'b1 || done0 !== 4'b0)
        begin n_err++; $display("FAIL shift_ctl[%0d]: got gnt=%b busy=%b done=%b want gnt=%b busy=1 done=0000", k, gnt0, busy0, done0, oh); end
    end
    @(negedge clk);
    n_cmp++; if (done0 !== oh) begin n_err++; $display("FAIL report_done: got %b want %b", done0, oh); end
    n_cmp++; if (gnt0 !== oh) begin n_err++; $display("FAIL report_gnt: got %b want %b", gnt0, oh); end
    n_cmp++; if (eq0 !== exp_eq) begin n_err++; $display("FAIL report_eq: got %b want %b (a=%h b=%h)", eq0, exp_eq, ea, eb); end
    @(negedge clk);
    n_cmp++; if (gnt0 !== 4'b0 || busy0 !== 1'b0 || done0 !== 4'b0)
      begin n_err++; $display("FAIL idle_after: got gnt=%b busy=%b done=%b want 0000/0/0000", gnt0, busy0, done0); end
    n_cmp++; if (eq0 !== exp_eq) begin n_err++; $display("FAIL eq_held_idle: got %b want %b", eq0, exp_eq); end
    ptr0 = exp_g;
    eqp0 = exp_eq;
    drive_ops();
  endtask

  task automatic txn1();
    int exp_g;
    logic [1:0] oh;
    logic ea, eb, exp_eq;
    exp_g = -1;
    for (int k = 1; k <= 2; k++)
      if (exp_g < 0 && req1[(ptr1 + k) % 2]) exp_g = (ptr1 + k) % 2;
    oh = 2'b01 << exp_g;
    ea = a1[exp_g];
    eb = b1[exp_g];
    exp_eq = (ea == eb);
    @(negedge clk);
    n_cmp++; if (gnt1 !== oh) begin n_err++; $display("FAIL w1_load_gnt: got %b want %b", gnt1, oh); end
    n_cmp++; if (eq1 !== eqp1) begin n_err++; $display("FAIL w1_eq_hold: got %b want %b", eq1, eqp1); end
    @(negedge clk);
    n_cmp++; if (xa1 !== ea || xb1 !== eb) begin n_err++; $display("FAIL w1_shift: got xa=%b xb=%b want %b %b", xa1, xb1, ea, eb); end
    n_cmp++; if (done1 !== 2'b00 || eq1 !== eqp1) begin n_err++; $display("FAIL w1_shift_ctl: got done=%b eq=%b want 00 %b", done1, eq1, eqp1); end
    @(negedge clk);
    n_cmp++; if (done1 !== oh) begin n_err++; $display("FAIL w1_done: got %b want %b", done1, oh); end
    n_cmp++; if (eq1 !== exp_eq) begin n_err++; $display("FAIL w1_eq: got %b want %b", eq1, exp_eq); end
    @(negedge clk);
    n_cmp++; if (busy1 !== 1'b0 || gnt1 !== 2'b00) begin n_err++; $display("FAIL w1_idle: got busy=%b gnt=%b want 0 00", busy1, gnt1); end
    ptr1 = exp_g;
    eqp1 = exp_eq;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0 = '0;
    req1 = '0;
    #1;
    n_cmp++; if (gnt0 !== 4'b0 || done0 !== 4'b0) begin n_err++; $display("FAIL reset_gnt_done: got %b %b want 0000 0000", gnt0, done0); end
    n_cmp++; if (eq0 !== 1'b0 || busy0 !== 1'b0) begin n_err++; $display("FAIL reset_eq_busy: got %b %b want 0 0", eq0, busy0); end
    n_cmp++; if (xa0 !== 1'b0 || xb0 !== 1'b0) begin n_err++; $display("FAIL reset_xab: got %b %b want 0 0", xa0, xb0); end
    n_cmp++; if (gnt1 !== 2'b0 || busy1 !== 1'b0 || eq1 !== 1'b0) begin n_err++; $display("FAIL reset_w1: got gnt=%b busy=%b eq=%b want 00 0 0", gnt1, busy1, eq1); end
    ptr0 = 3; ptr1 = 1; eqp0 = 1'b0; eqp1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_match();
    opa[0] = 8'hA5; opb[0] = 8'hA5;
    drive_ops();
    req0 = 4'b0001;
    txn0(-1);
    req0 = 4'b0000;
  endtask

  task automatic test_msb_mismatch();
    opa[1] = 8'h80; opb[1] = 8'h00;
    drive_ops();
    req0 = 4'b0010;
    txn0(-1);
    req0 = 4'b0000;
  endtask

  task automatic test_back_to_back();
    test_reset();
    for (int i = 0; i < 4; i++) begin opa[i] = $urandom; opb[i] = (i % 2) ? opa[i] : $urandom; end
    drive_ops();
    req0 = 4'b1111;
    for (int t = 0; t < 6; t++) txn0(-1);
    req0 = 4'b0000;
  endtask

  task automatic test_req_drop();
    opa[2] = 8'h3C; opb[2] = 8'h3C;
    drive_ops();
    req0 = 4'b0100;
    txn0(2);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++; if (busy0 !== 1'b0 || gnt0 !== 4'b0) begin n_err++; $display("FAIL drop_no_regrant: got busy=%b gnt=%b want 0 0000", busy0, gnt0); end
    end
  endtask

  task automatic test_reset_mid();
    opa[0] = 8'h11; opb[0] = 8'h11;
    opa[1] = 8'h5A; opb[1] = 8'h5B;
    drive_ops();
    req0 = 4'b0001;
    @(negedge clk);
    for (int k = 0; k < 5; k++) @(negedge clk);
    #2 rst_n = 1'b0;
    req0 = 4'b1010;
    #1;
    n_cmp++; if (gnt0 !== 4'b0 || busy0 !== 1'b0) begin n_err++; $display("FAIL midrst_gnt_busy: got %b %b want 0000 0", gnt0, busy0); end
    n_cmp++; if (xa0 !== 1'b0 || xb0 !== 1'b0 || eq0 !== 1'b0) begin n_err++; $display("FAIL midrst_xab_eq: got %b %b %b want 0 0 0", xa0, xb0, eq0); end
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 2) rst_n = 1'b1;
      n_cmp++; if (done0 !== 4'b0) begin n_err++; $display("FAIL midrst_no_done: got %b want 0000", done0); end
      if (k == 2) break;
    end
    ptr0 = 3;
    eqp0 = 1'b0;
    txn0(-1);
    req0 = 4'b0000;
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 4; i++) begin
        opa[i] = $urandom;
        opb[i] = ($urandom_range(0, 1) == 0) ? opa[i] : opa[i] ^ (8'h01 << $urandom_range(0, 7));
      end
      drive_ops();
      if ($urandom_range(0, 3) == 0) begin
        req0 = 4'b0000;
        @(negedge clk);
        n_cmp++; if (busy0 !== 1'b0 || gnt0 !== 4'b0) begin n_err++; $display("FAIL rand_idle: got busy=%b gnt=%b want 0 0000", busy0, gnt0); end
      end
      req0 = 4'($urandom_range(1, 15));
      txn0(-1);
    end
    req0 = 4'b0000;
  endtask

  task automatic test_width1();
    a1 = 2'b01; b1 = 2'b00;
    req1 = 2'b01;
    txn1();
    a1 = 2'b01; b1 = 2'b01;
    txn1();
    a1 = 2'b10; b1 = 2'b10;
    req1 = 2'b11;
    txn1();
    a1 = 2'b00; b1 = 2'b11;
    txn1();
    req1 = 2'b00;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin opa[i] = '0; opb[i] = '0; end
    test_reset();
    test_single_match();
    test_msb_mismatch();
    test_back_to_back();
    test_req_drop();
    test_reset_mid();
    test_random();
    test_width1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
